bitwise_unit_arbiter: RTL and testbench

Shares a single 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters, such as the ALU issue path and the branch/compare path. Arbitration is round-robin, and each requester uses a valid/ready handshake. The result goes into a one-entry output register with backpressure and is tagged with the winning requester's ID. The block sits between the requesters and the shared combinational logic unit, and owns all sequencing of that unit.

---
 rtl/bitwise_unit_arbiter.sv | 105 ++++++++++
 tb/tb_bitwise_unit_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bitwise_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NOR) between two
// valid/ready requesters, feeding a one-entry, backpressured, ID-tagged result register.
module bitwise_unit_arbiter #(
  parameter int SIZE = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [1:0]      req0_op,
  input  logic [SIZE-1:0] req0_a,
  input  logic [SIZE-1:0] req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [1:0]      req1_op,
  input  logic [SIZE-1:0] req1_a,
  input  logic [SIZE-1:0] req1_b,
  output logic            req1_ready,
  output logic            res_valid,
  output logic [SIZE-1:0] res_data,
  output logic            res_id,
  input  logic            res_ready
);

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  logic            res_valid_q, res_valid_d;
  logic [SIZE-1:0] res_data_q, res_data_d;
  logic            res_id_q, res_id_d;
  logic            last_q, last_d;

  logic            accept_en;
  logic            winner;
  logic            grant;
  logic [1:0]      win_op;
  logic [SIZE-1:0] win_a;
  logic [SIZE-1:0] win_b;

  function automatic logic [SIZE-1:0] logic_op(input logic [1:0] op,
                                               input logic [SIZE-1:0] a,
                                               input logic [SIZE-1:0] b);
    logic [SIZE-1:0] r;
    case (op_e'(op))
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    accept_en = !res_valid_q || res_ready;
    if (req0_valid && req1_valid) begin
      winner = ~last_q;
    end else begin
      winner = !req0_valid;
    end
    grant      = accept_en && (req0_valid || req1_valid) && !reset;
    req0_ready = grant && !winner;
    req1_ready = grant && winner;

    win_op = winner ? req1_op : req0_op;
    win_a  = winner ? req1_a  : req0_a;
    win_b  = winner ? req1_b  : req0_b;

    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    last_d      = last_q;
    if (grant) begin
      res_valid_d = 1'b1;
      res_data_d  = logic_op(win_op, win_a, win_b);
      res_id_d    = winner;
      last_d      = winner;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // last resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clock) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      last_q      <= last_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// Table-driven bench for bitwise_unit_arbiter: each row drives one cycle, checks readies,
// and a scoreboard queue holds hand-computed results until the output register drains them.
module tb_bitwise_unit_arbiter;

  typedef struct {
    logic        rst;
    logic        v0;
    logic [1:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        v1;
    logic [1:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        rr;
    logic        er0;
    logic        er1;
    logic [31:0] eres;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        id;
  } sb_t;

  localparam int NVEC = 25;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [1:0]  req0_op = 2'b00;
  logic [31:0] req0_a = '0;
  logic [31:0] req0_b = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [1:0]  req1_op = 2'b00;
  logic [31:0] req1_a = '0;
  logic [31:0] req1_b = '0;
  logic        req1_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_id;
  logic        res_ready = 1'b0;

  vec_t        vecs[NVEC];
  sb_t         sb_q[$];
  logic [31:0] hold_data;
  logic        hold_id;
  logic        known;
  int          n_cmp;
  int          n_err;

  bitwise_unit_arbiter #(.SIZE(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ready  (res_ready)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic v0, input logic [1:0] op0,
                              input logic [31:0] a0, input logic [31:0] b0,
                              input logic v1, input logic [1:0] op1,
                              input logic [31:0] a1, input logic [31:0] b1,
                              input logic rr, input logic er0, input logic er1,
                              input logic [31:0] eres);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.rr = rr; v.er0 = er0; v.er1 = er1; v.eres = eres;
    return v;
  endfunction

  task automatic cmp(input int row, input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL row%0d %s: got %h expected %h", row, name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset      = v.rst;
    req0_valid = v.v0;
    req0_op    = v.op0;
    req0_a     = v.a0;
    req0_b     = v.b0;
    req1_valid = v.v1;
    req1_op    = v.op1;
    req1_a     = v.a1;
    req1_b     = v.b1;
    res_ready  = v.rr;
  endtask

  // Compares readies and the output register before the edge, then advances the model.
  task automatic checkOutput(input int row, input vec_t v);
    sb_t e;
    cmp(row, "req0_ready", {31'd0, req0_ready}, {31'd0, v.er0});
    cmp(row, "req1_ready", {31'd0, req1_ready}, {31'd0, v.er1});
    if (known) begin
      cmp(row, "res_valid", {31'd0, res_valid}, {31'd0, sb_q.size() != 0});
      if (sb_q.size() != 0) begin
        cmp(row, "res_data", res_data, sb_q[0].data);
        cmp(row, "res_id", {31'd0, res_id}, {31'd0, sb_q[0].id});
      end else begin
        cmp(row, "res_data_hold", res_data, hold_data);
        cmp(row, "res_id_hold", {31'd0, res_id}, {31'd0, hold_id});
      end
    end
    if (v.rst) begin
      sb_q.delete();
      hold_data = '0;
      hold_id   = 1'b0;
      known     = 1'b1;
    end else begin
      if (sb_q.size() != 0 && v.rr) begin
        hold_data = sb_q[0].data;
        hold_id   = sb_q[0].id;
        void'(sb_q.pop_front());
      end
      if (v.er0 || v.er1) begin
        e.data = v.eres;
        e.id   = v.er1;
        sb_q.push_back(e);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    known = 1'b0;
    hold_data = '0;
    hold_id = 1'b0;

    // reset held two cycles with both requesters pending
    vecs[0]  = mk(1, 1, 2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 2'b11, 32'hFFFF_0000, 32'h0000_00FF, 1, 0, 0, 32'h0);
    vecs[1]  = mk(1, 1, 2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 2'b11, 32'hFFFF_0000, 32'h0000_00FF, 1, 0, 0, 32'h0);
    // contention: grants 0,1,0,1,0,1 across all four ops
    vecs[2]  = mk(0, 1, 2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 2'b11, 32'hFFFF_0000, 32'h0000_00FF, 1, 1, 0, 32'h0F0F_0000);
    vecs[3]  = mk(0, 1, 2'b01, 32'h1234_0000, 32'h0000_5678, 1, 2'b11, 32'hFFFF_0000, 32'h0000_00FF, 1, 0, 1, 32'h0000_FF00);
    vecs[4]  = mk(0, 1, 2'b01, 32'h1234_0000, 32'h0000_5678, 1, 2'b10, 32'hAAAA_AAAA, 32'hFFFF_0000, 1, 1, 0, 32'h1234_5678);
    vecs[5]  = mk(0, 1, 2'b10, 32'h0F0F_F0F0, 32'hFFFF_FFFF, 1, 2'b10, 32'hAAAA_AAAA, 32'hFFFF_0000, 1, 0, 1, 32'h5555_AAAA);
    vecs[6]  = mk(0, 1, 2'b10, 32'h0F0F_F0F0, 32'hFFFF_FFFF, 1, 2'b00, 32'hDEAD_BEEF, 32'hFFFF_0000, 1, 1, 0, 32'hF0F0_0F0F);
    vecs[7]  = mk(0, 1, 2'b01, 32'hF0F0_0000, 32'h0000_0F0F, 1, 2'b00, 32'hDEAD_BEEF, 32'hFFFF_0000, 1, 0, 1, 32'hDEAD_0000);
    // single OR from requester 0
    vecs[8]  = mk(0, 1, 2'b01, 32'hF0F0_0000, 32'h0000_0F0F, 0, 2'b00, 32'h0, 32'h0, 1, 1, 0, 32'hF0F0_0F0F);
    // backpressure for three cycles, then requester 1 wins with no bubble
    vecs[9]  = mk(0, 1, 2'b00, 32'h1111_1111, 32'h0101_0101, 1, 2'b01, 32'h8000_0000, 32'h0000_0001, 0, 0, 0, 32'h0);
    vecs[10] = mk(0, 1, 2'b00, 32'h1111_1111, 32'h0101_0101, 1, 2'b01, 32'h8000_0000, 32'h0000_0001, 0, 0, 0, 32'h0);
    vecs[11] = mk(0, 1, 2'b00, 32'h1111_1111, 32'h0101_0101, 1, 2'b01, 32'h8000_0000, 32'h0000_0001, 0, 0, 0, 32'h0);
    vecs[12] = mk(0, 1, 2'b00, 32'h1111_1111, 32'h0101_0101, 1, 2'b01, 32'h8000_0000, 32'h0000_0001, 1, 0, 1, 32'h8000_0001);
    vecs[13] = mk(0, 1, 2'b00, 32'h1111_1111, 32'h0101_0101, 0, 2'b00, 32'h0, 32'h0, 1, 1, 0, 32'h0101_0101);
    // drain without refill, data holds, then a lone request is accepted at once
    vecs[14] = mk(0, 0, 2'b00, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0);
    vecs[15] = mk(0, 0, 2'b00, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0);
    vecs[16] = mk(0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b11, 32'h0000_FFFF, 32'h00FF_0000, 0, 0, 1, 32'hFF00_0000);
    // pending result stalled, then reset discards it; only req1 valid afterwards
    vecs[17] = mk(0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b10, 32'h0000_00FF, 32'h0000_0F0F, 0, 0, 0, 32'h0);
    vecs[18] = mk(1, 0, 2'b00, 32'h0, 32'h0, 1, 2'b10, 32'h0000_00FF, 32'h0000_0F0F, 0, 0, 0, 32'h0);
    vecs[19] = mk(0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b10, 32'h0000_00FF, 32'h0000_0F0F, 1, 0, 1, 32'h0000_0FF0);
    // reset with both valid: requester 0 wins first afterwards
    vecs[20] = mk(1, 1, 2'b00, 32'h1357_9BDF, 32'hFFFF_FFFF, 1, 2'b10, 32'h0000_00FF, 32'h0000_0F0F, 0, 0, 0, 32'h0);
    vecs[21] = mk(0, 1, 2'b00, 32'h1357_9BDF, 32'hFFFF_FFFF, 1, 2'b10, 32'h0000_00FF, 32'h0000_0F0F, 1, 1, 0, 32'h1357_9BDF);
    vecs[22] = mk(0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b10, 32'h0000_00FF, 32'h0000_0F0F, 1, 0, 1, 32'h0000_0FF0);
    vecs[23] = mk(0, 0, 2'b00, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0);
    vecs[24] = mk(0, 0, 2'b00, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0);

    applyStimulus(vecs[0]);
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clock);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i, vecs[i]);
    end

    cmp(NVEC, "scoreboard_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
